// File: rtl/divu_seq_pkg.sv
// Shared CPU constants: ALU/funct codes, HI/LO access codes and divider states.
package divu_seq_pkg;

  localparam int unsigned HILO_W = 2;

  // HI/LO access requested by the instruction in decode
  localparam logic [HILO_W-1:0] HILO_MFHI = 2'b00;
  localparam logic [HILO_W-1:0] HILO_MFLO = 2'b01;
  localparam logic [HILO_W-1:0] HILO_NONE = 2'b10;

  // Sequential divider control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

  // ALU operation select
  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_NOR  = 4'h5,
    ALU_SLT  = 4'h6,
    ALU_SLTU = 4'h7,
    ALU_SLL  = 4'h8,
    ALU_SRL  = 4'h9,
    ALU_SRA  = 4'hA,
    ALU_LUI  = 4'hB
  } alu_op_e;

  // R-type funct codes touching HI/LO
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  // True when the instruction reads HI or LO
  function automatic logic is_hilo_read(input logic [HILO_W-1:0] op);
    return (op == HILO_MFHI) || (op == HILO_MFLO);
  endfunction

endpackage

// File: rtl/divu_seq_step.sv
// One restoring division step: shift {rem,quo} left, conditionally subtract divisor.
module div_step
  import divu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_c_o,
  output logic [WIDTH-1:0] quo_c_o
);

  logic [WIDTH:0] rem_sh;
  logic           sub;

  // Shifted remainder needs one extra bit so the compare never overflows
  always_comb begin
    rem_sh  = {rem_i, quo_i[WIDTH-1]};
    sub     = (rem_sh >= {1'b0, divisor_i});
    rem_c_o = sub ? WIDTH'(rem_sh - {1'b0, divisor_i}) : rem_sh[WIDTH-1:0];
    quo_c_o = {quo_i[WIDTH-2:0], sub};
  end

endmodule

// File: rtl/divu_seq.sv
// Multi-cycle unsigned divider with HI/LO registers and pipeline stall request.
module divu_seq
  import divu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_start,
  input  logic [1:0]       hilo_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] step_rem, step_quo;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvsr_q),
    .rem_c_o   (step_rem),
    .quo_c_o   (step_quo)
  );

  // State, datapath and HI/LO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next state: latch operands, iterate WIDTH steps, then commit HI/LO once
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (div_start) begin
          rem_d   = '0;
          quo_d   = dividend;
          dvsr_d  = divisor;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        hi_d    = rem_q;
        lo_d    = quo_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status decodes; stall holds HI/LO readers and new divides while occupied
  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign stall = busy & (is_hilo_read(hilo_op) | div_start);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_divu_seq.sv
// Bench for divu_seq: directed vectors, pipeline-interaction sequences, random vs. model.
module tb_divu_seq;
  import divu_seq_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned NVEC = 10;
  localparam int unsigned NRAND = 1000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         div_start;
  logic [1:0]   hilo_op;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, stall;
  logic [W-1:0] hi, lo;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  divu_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .div_start (div_start),
    .hilo_op   (hilo_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference: plain integer division; a zero divisor gives all-ones / dividend
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Issue one divide (caller sits just after a rising edge) and wait for completion
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic [1:0] hop,
                        output int lat, output int busy_cyc, output bit stall_seen,
                        output bit hold_bad);
    logic [31:0] hi0, lo0;
    hi0 = hi;
    lo0 = lo;
    div_start = 1'b1;
    dividend  = a;
    divisor   = b;
    hilo_op   = hop;
    @(posedge clk); #1;
    div_start = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    lat = 0; busy_cyc = 0; stall_seen = 1'b0; hold_bad = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (stall) stall_seen = 1'b1;
      if (hi !== hi0 || lo !== lo0) hold_bad = 1'b1;
      if (done) begin
        lat = c;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, bcyc, c_done;
    bit sseen, hbad, bad, got_done;
    logic [31:0] eq, er, a, b;

    vecs[0] = '{32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 32'd0};
    vecs[1] = '{32'd5,         32'd0,          32'hFFFF_FFFF, 32'd5};
    vecs[2] = '{32'd1000,      32'd3,          32'd333,       32'd1};
    vecs[3] = '{32'd0,         32'd5,          32'd0,         32'd0};
    vecs[4] = '{32'd7,         32'd7,          32'd1,         32'd0};
    vecs[5] = '{32'd6,         32'd7,          32'd0,         32'd6};
    vecs[6] = '{32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000};
    vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'd1,         32'd0};
    vecs[8] = '{32'hDEAD_BEEF, 32'h10,         32'h0DEA_DBEE, 32'hF};
    vecs[9] = '{32'h1234_5678, 32'h100,        32'h0012_3456, 32'h78};

    // Reset with busy-provoking inputs applied
    rst_n = 1'b0; div_start = 1'b1; hilo_op = HILO_MFHI; dividend = 100; divisor = 7;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_hi",    hi, 32'd0);
    check("rst_lo",    lo, 32'd0);
    div_start = 1'b0; hilo_op = HILO_NONE;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 100/7 with no HI/LO access
    do_div(32'd100, 32'd7, HILO_NONE, lat, bcyc, sseen, hbad);
    check("d100_7_latency", 32'(lat), 32'd33);
    check("d100_7_busycyc", 32'(bcyc), 32'd33);
    check("d100_7_stall",   32'(sseen), 32'd0);
    check("d100_7_hold",    32'(hbad), 32'd0);
    check("d100_7_lo", lo, 32'd14);
    check("d100_7_hi", hi, 32'd2);
    check("d100_7_idle", 32'(busy), 32'd0);

    // IDLE never stalls a HI/LO read
    hilo_op = HILO_MFHI; #1;
    check("idle_mfhi_stall", 32'(stall), 32'd0);
    hilo_op = HILO_MFLO; #1;
    check("idle_mflo_stall", 32'(stall), 32'd0);
    hilo_op = HILO_NONE;

    // Directed vector table
    for (int i = 0; i < NVEC; i++) begin
      do_div(vecs[i].a, vecs[i].b, HILO_NONE, lat, bcyc, sseen, hbad);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].q);
      check($sformatf("vec%0d_hi", i), hi, vecs[i].r);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd33);
    end

    // Start together with mflo in IDLE: no stall, old LO visible; later mflo stalls
    div_start = 1'b1; dividend = 32'd1000; divisor = 32'd7; hilo_op = HILO_MFLO; #1;
    check("start_mflo_stall", 32'(stall), 32'd0);
    check("start_mflo_oldlo", lo, vecs[NVEC-1].q);
    @(posedge clk); #1;
    div_start = 1'b0; hilo_op = HILO_NONE; dividend = 0; divisor = 0;
    repeat (3) @(posedge clk);
    #1;
    hilo_op = HILO_MFLO;
    bad = 1'b0; got_done = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!stall) bad = 1'b1;
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    check("mflo_stall_held", 32'(bad), 32'd0);
    check("mflo_done_seen",  32'(got_done), 32'd1);
    @(posedge clk); #1;
    check("mflo_release", 32'(stall), 32'd0);
    check("mflo_lo", lo, 32'd142);
    check("mflo_hi", hi, 32'd6);
    hilo_op = HILO_NONE;

    // Second start during a divide is ignored and stalled, then re-issued
    div_start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    div_start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    div_start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
    bad = 1'b0; c_done = 0;
    for (int c = 10; c < 110; c++) begin
      @(negedge clk);
      if (busy && !stall) bad = 1'b1;
      if (done) begin
        c_done = c;
        break;
      end
    end
    check("dup_stall", 32'(bad), 32'd0);
    check("dup_lat", 32'(c_done), 32'd33);
    @(posedge clk); #1;
    check("dup_first_lo", lo, 32'd14);
    check("dup_first_hi", hi, 32'd2);
    check("dup_idle_stall", 32'(stall), 32'd0);
    do_div(32'd1000, 32'd3, HILO_NONE, lat, bcyc, sseen, hbad);
    check("dup_second_lo", lo, 32'd333);
    check("dup_second_hi", hi, 32'd1);

    // Reset mid-division aborts without a HI/LO write
    div_start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk); #1;
    div_start = 1'b0; hilo_op = HILO_MFHI;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; #1;
    check("abort_busy",  32'(busy),  32'd0);
    check("abort_done",  32'(done),  32'd0);
    check("abort_stall", 32'(stall), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; hilo_op = HILO_NONE;
    got_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) got_done = 1'b1;
    end
    check("abort_no_done", 32'(got_done), 32'd0);
    check("abort_hold_lo", lo, 32'd0);
    @(posedge clk); #1;
    do_div(32'd1000, 32'd3, HILO_NONE, lat, bcyc, sseen, hbad);
    check("after_abort_lo", lo, 32'd333);
    check("after_abort_hi", hi, 32'd1);
    check("after_abort_lat", 32'(lat), 32'd33);

    // Random operands against the arithmetic model
    for (int i = 0; i < NRAND; i++) begin
      a = $urandom;
      case (i % 10)
        0: b = 32'd0;
        1: b = 32'd1;
        2, 3: b = 32'($urandom_range(2, 255));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      ref_div(a, b, eq, er);
      do_div(a, b, {1'b1, 1'($urandom_range(0, 1))}, lat, bcyc, sseen, hbad);
      check($sformatf("rnd%0d_lo %0h/%0h", i, a, b), lo, eq);
      check($sformatf("rnd%0d_hi %0h/%0h", i, a, b), hi, er);
      check($sformatf("rnd%0d_lat", i), 32'(lat), 32'd33);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/divu_seq.md
DIVU_SEQ -- requirements
Module: divu_seq

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL provide parameter CNT_W, default 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 div_start  in  1  divu issue request from decode (DIVOperation).
REQ-006 hilo_op  in  2  00 = mfhi read, 01 = mflo read, 10/11 = no HI/LO access.
REQ-007 dividend  in  WIDTH  unsigned rs operand, sampled with div_start.
REQ-008 divisor  in  WIDTH  unsigned rt operand, sampled with div_start.
REQ-009 busy  out  1  high while a division is in progress (BUSY or DONE state).
REQ-010 done  out  1  one-cycle pulse in the cycle HI/LO are written.
REQ-011 stall  out  1  pipeline hold request to the hazard unit.
REQ-012 hi  out  WIDTH  remainder register.
REQ-013 lo  out  WIDTH  quotient register.

Function
REQ-014 States SHALL be IDLE, BUSY and DONE, encoded in 2 bits.
REQ-015 IDLE: div_start=1 at a rising edge SHALL latch dividend and divisor, clear the partial remainder, clear cnt to 0 and enter BUSY.
REQ-016 BUSY: each cycle SHALL perform one restoring shift-subtract step: shift {rem,quo} left by 1; if rem >= divisor, subtract divisor and set quo[0]=1.
REQ-017 BUSY SHALL increment cnt every cycle and enter DONE after the edge at which cnt==WIDTH-1, i.e. after exactly WIDTH steps.
REQ-018 DONE SHALL write hi<=rem and lo<=quo, assert done for one cycle, then return to IDLE.
REQ-019 Latency: for start sampled at edge N, hi and lo SHALL hold the new values from edge N+WIDTH+1, which is 33 cycles for WIDTH=32.
REQ-020 hi and lo SHALL change only in DONE; they retain their values in every other state.
REQ-021 Divide by zero SHALL NOT trap; the natural algorithm result is required: lo = all ones, hi = dividend.
REQ-022 stall SHALL be combinational: stall = busy AND (hilo_op is 00 or 01, OR div_start=1).
REQ-023 div_start while busy SHALL be ignored (not queued); the stall from REQ-022 holds the instruction until the unit returns to IDLE.
REQ-024 In IDLE, stall SHALL be 0 regardless of inputs, so mfhi/mflo read the current hi/lo without delay.
REQ-025 In the DONE cycle, stall SHALL remain asserted for pending HI/LO reads; the read proceeds in the following IDLE cycle with updated values.
REQ-026 div_start and hilo_op active together in IDLE SHALL start the division and SHALL NOT stall that cycle; that read returns the old hi/lo.
REQ-027 Operand changes after the start edge SHALL NOT affect the result.

Reset
REQ-028 rst_n low SHALL asynchronously force state=IDLE, cnt=0, hi=0, lo=0 and internal rem/quo/divisor registers to 0.
REQ-029 While in reset: busy=0, done=0, stall=0.
REQ-030 Reset mid-division SHALL abort it with no HI/LO write; the first start after reset release begins a fresh division.

Structure
REQ-031 State encodings and hilo_op codes (HILO_MFHI=00, HILO_MFLO=01, HILO_NONE=10) SHALL reside in the shared CPU constants package, alongside the ALU/Funct codes.
REQ-032 The single iteration step (shift, compare, conditional subtract) SHALL be the combinational sub-module div_step; the FSM, counter and HI/LO registers reside in divu_seq.

Verification
REQ-033 100/7 start -> busy for 33 cycles, done pulse at cycle 33, lo=14, hi=2; stall=0 throughout when hilo_op=10.
REQ-034 0xFFFFFFFF/1 -> lo=0xFFFFFFFF, hi=0; then 5/0 -> lo=0xFFFFFFFF, hi=5.
REQ-035 mflo (hilo_op=01) issued 3 cycles after start -> stall high through the DONE cycle, low in the next cycle; lo equals the new quotient.
REQ-036 Second div_start at cycle 10 of a division -> ignored; stall high; the first result completes unchanged; re-issue after IDLE produces the second result.
REQ-037 rst_n pulsed low at cycle 20 of 1000/3 -> immediate IDLE with hi=lo=0, no done pulse; a new start of 1000/3 then yields lo=333, hi=1.
REQ-038 Randomized 1000 operand pairs, including divisor 0 and 1 -> hi and lo match a reference model of dividend/divisor and dividend%divisor.
